// File: rtl/control_pc_unit.sv
// control_pc_unit
//   Single-cycle instruction decoder and program-counter sequencer for the
//   8-bit processor. Decodes INSTRUCTION[31:24] into ALU / operand-mux /
//   register-file / data-memory controls, resolves j/beq/bne with ZERO,
//   stalls on BUSYWAIT for memory ops, halts on HALT_OPCODE and counts
//   retired instructions.
//
// Ports
//   CLK          rising-edge clock
//   RESET        synchronous, active-low reset
//   INSTRUCTION  [31:24] opcode, [23:16] rd/branch offset, [15:8] rt, [7:0] rs/imm
//   ZERO         ALU zero flag (same cycle)
//   BUSYWAIT     data-memory busy
//   PC           registered program counter
//   ALU_SELECT   000 FWD, 001 ADD, 010 AND, 011 OR, 100 SHIFT, 101 MULT
//   SHIFT_SEL    00 srl, 01 sll, 10 sra, 11 ror
//   IMM_SEL      ALU DATAIN2 from INSTRUCTION[7:0]
//   NEG_SEL      ALU DATAIN2 negated
//   WRITEENABLE  register-file write enable
//   WRITE_SRC    0 ALU result, 1 memory read data
//   MEM_READ     data-memory read strobe
//   MEM_WRITE    data-memory write strobe
//   HALTED       high while halted
//   ILLEGAL      sticky undefined-opcode flag
//   RETIRED      saturating retired-instruction counter
module control_pc_unit #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic        ZERO,
   input  logic        BUSYWAIT,
   output logic [31:0] PC,
   output logic [2:0]  ALU_SELECT,
   output logic [1:0]  SHIFT_SEL,
   output logic        IMM_SEL,
   output logic        NEG_SEL,
   output logic        WRITEENABLE,
   output logic        WRITE_SRC,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic        HALTED,
   output logic        ILLEGAL,
   output logic [15:0] RETIRED
);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        illegal_q, illegal_d;
   logic        halted_q, halted_d;
   logic [15:0] retired_q, retired_d;

   logic [7:0]  opcode;
   logic [7:0]  offset;
   logic [2:0]  dec_alu;
   logic [1:0]  dec_shift;
   logic        dec_imm, dec_neg, dec_we, dec_wsrc, dec_mrd, dec_mwr;
   logic        is_j, is_beq, is_bne, is_halt, is_undef;
   logic        active, is_mem, take;
   logic [31:0] pc_plus4, target;
   logic        unused_bits;

   assign opcode      = INSTRUCTION[31:24];
   assign offset      = INSTRUCTION[23:16];
   assign unused_bits = ^INSTRUCTION[15:0];

   always_comb begin
      dec_alu   = '0;
      dec_shift = '0;
      dec_imm   = 1'b0;
      dec_neg   = 1'b0;
      dec_we    = 1'b0;
      dec_wsrc  = 1'b0;
      dec_mrd   = 1'b0;
      dec_mwr   = 1'b0;
      is_j      = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_halt   = 1'b0;
      is_undef  = 1'b0;
      if (opcode == HALT_OPCODE) begin
         is_halt = 1'b1;
      end else begin
         case (opcode)
            8'h00: begin dec_imm = 1'b1; dec_we = 1'b1; end
            8'h01: dec_we = 1'b1;
            8'h02: begin dec_alu = 3'b001; dec_we = 1'b1; end
            8'h03: begin dec_alu = 3'b001; dec_neg = 1'b1; dec_we = 1'b1; end
            8'h04: begin dec_alu = 3'b010; dec_we = 1'b1; end
            8'h05: begin dec_alu = 3'b011; dec_we = 1'b1; end
            8'h06: is_j = 1'b1;
            8'h07: begin dec_alu = 3'b001; dec_neg = 1'b1; is_beq = 1'b1; end
            8'h08: begin dec_alu = 3'b001; dec_neg = 1'b1; is_bne = 1'b1; end
            8'h09: begin dec_alu = 3'b101; dec_we = 1'b1; end
            8'h0A: begin dec_alu = 3'b100; dec_shift = 2'b01; dec_imm = 1'b1; dec_we = 1'b1; end
            8'h0B: begin dec_alu = 3'b100; dec_shift = 2'b00; dec_imm = 1'b1; dec_we = 1'b1; end
            8'h0C: begin dec_alu = 3'b100; dec_shift = 2'b10; dec_imm = 1'b1; dec_we = 1'b1; end
            8'h0D: begin dec_alu = 3'b100; dec_shift = 2'b11; dec_imm = 1'b1; dec_we = 1'b1; end
            8'h0E: begin dec_mrd = 1'b1; dec_wsrc = 1'b1; dec_we = 1'b1; end
            8'h0F: begin dec_imm = 1'b1; dec_mrd = 1'b1; dec_wsrc = 1'b1; dec_we = 1'b1; end
            8'h10: dec_mwr = 1'b1;
            8'h11: begin dec_imm = 1'b1; dec_mwr = 1'b1; end
            default: is_undef = 1'b1;
         endcase
      end
   end

   // Controls are only live while out of reset and not halted.
   assign active      = RESET && (state_q != S_HALT);
   assign is_mem      = dec_mrd | dec_mwr;
   assign ALU_SELECT  = active ? dec_alu   : '0;
   assign SHIFT_SEL   = active ? dec_shift : '0;
   assign IMM_SEL     = active & dec_imm;
   assign NEG_SEL     = active & dec_neg;
   assign WRITE_SRC   = active & dec_wsrc;
   assign MEM_READ    = active & dec_mrd;
   assign MEM_WRITE   = active & dec_mwr;
   // Loads write back only on the completion cycle.
   assign WRITEENABLE = active & dec_we & ~(dec_mrd & BUSYWAIT);

   assign pc_plus4 = pc_q + 32'd4;
   assign target   = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};
   assign take     = active & (is_j | (is_beq & ZERO) | (is_bne & ~ZERO));

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      illegal_d = illegal_q;
      halted_d  = halted_q;
      retired_d = retired_q;
      if (state_q != S_HALT) begin
         if (is_halt) begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            retired_d = (retired_q == '1) ? retired_q : retired_q + 16'd1;
         end else if (is_mem && BUSYWAIT) begin
            state_d = S_STALL;
         end else begin
            state_d   = S_RUN;
            pc_d      = take ? target : pc_plus4;
            retired_d = (retired_q == '1) ? retired_q : retired_q + 16'd1;
            if (is_undef) illegal_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= S_RUN;
         pc_q      <= PC_RESET;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         illegal_q <= illegal_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
      end
   end

   assign PC      = pc_q;
   assign HALTED  = halted_q;
   assign ILLEGAL = illegal_q;
   assign RETIRED = retired_q;

endmodule

// File: tb/tb_control_pc_unit.sv
module tb_control_pc_unit;

   logic        CLK;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic        ZERO;
   logic        BUSYWAIT;
   logic [31:0] PC;
   logic [2:0]  ALU_SELECT;
   logic [1:0]  SHIFT_SEL;
   logic        IMM_SEL;
   logic        NEG_SEL;
   logic        WRITEENABLE;
   logic        WRITE_SRC;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic        HALTED;
   logic        ILLEGAL;
   logic [15:0] RETIRED;

   int checks = 0;
   int errors = 0;

   control_pc_unit #(
      .PC_RESET    (32'h0000_0000),
      .HALT_OPCODE (8'hFF)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTRUCTION (INSTRUCTION),
      .ZERO        (ZERO),
      .BUSYWAIT    (BUSYWAIT),
      .PC          (PC),
      .ALU_SELECT  (ALU_SELECT),
      .SHIFT_SEL   (SHIFT_SEL),
      .IMM_SEL     (IMM_SEL),
      .NEG_SEL     (NEG_SEL),
      .WRITEENABLE (WRITEENABLE),
      .WRITE_SRC   (WRITE_SRC),
      .MEM_READ    (MEM_READ),
      .MEM_WRITE   (MEM_WRITE),
      .HALTED      (HALTED),
      .ILLEGAL     (ILLEGAL),
      .RETIRED     (RETIRED)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0; INSTRUCTION = '0; ZERO = 1'b0; BUSYWAIT = 1'b0;
      step(); step();
      RESET = 1'b1;
      checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc0 got %h exp %h", PC, 32'h0); end
      INSTRUCTION = 32'h0E01_0002; BUSYWAIT = 1'b1;
      #1;
      checks++; if (MEM_READ !== 1'b1) begin errors++; $display("FAIL rst_lwd_mr got %b exp 1", MEM_READ); end
      step();
      checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_stall_pc got %h exp %h", PC, 32'h0); end
      RESET = 1'b0;
      #1;
      checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL rst_mr_drop got %b exp 0", MEM_READ); end
      checks++; if (WRITEENABLE !== 1'b0) begin errors++; $display("FAIL rst_we_drop got %b exp 0", WRITEENABLE); end
      step(); step();
      RESET = 1'b1; BUSYWAIT = 1'b0;
      checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", PC, 32'h0); end
      checks++; if (RETIRED !== 16'h0) begin errors++; $display("FAIL rst_retired got %h exp 0", RETIRED); end
      checks++; if (ILLEGAL !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", ILLEGAL); end
      checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", HALTED); end
   endtask

   task automatic test_sequence();
      INSTRUCTION = 32'h0001_0005;
      #1;
      checks++; if ({ALU_SELECT, IMM_SEL, NEG_SEL, WRITEENABLE} !== 6'b000_1_0_1) begin
         errors++; $display("FAIL loadi_ctl got %b exp 000101", {ALU_SELECT, IMM_SEL, NEG_SEL, WRITEENABLE}); end
      step();
      checks++; if (PC !== 32'h4) begin errors++; $display("FAIL seq_pc1 got %h exp 4", PC); end
      INSTRUCTION = 32'h0202_0103;
      #1;
      checks++; if ({ALU_SELECT, IMM_SEL, NEG_SEL, WRITEENABLE} !== 6'b001_0_0_1) begin
         errors++; $display("FAIL add_ctl got %b exp 001001", {ALU_SELECT, IMM_SEL, NEG_SEL, WRITEENABLE}); end
      step();
      checks++; if (PC !== 32'h8) begin errors++; $display("FAIL seq_pc2 got %h exp 8", PC); end
      INSTRUCTION = 32'h0303_0201;
      #1;
      checks++; if ({ALU_SELECT, IMM_SEL, NEG_SEL, WRITEENABLE} !== 6'b001_0_1_1) begin
         errors++; $display("FAIL sub_ctl got %b exp 001011", {ALU_SELECT, IMM_SEL, NEG_SEL, WRITEENABLE}); end
      step();
      checks++; if (PC !== 32'hC) begin errors++; $display("FAIL seq_pc3 got %h exp c", PC); end
      checks++; if (RETIRED !== 16'd3) begin errors++; $display("FAIL seq_retired got %0d exp 3", RETIRED); end
   endtask

   task automatic test_branch();
      INSTRUCTION = 32'h0604_0000;  // j +4 words from 0x0C
      step();
      checks++; if (PC !== 32'h20) begin errors++; $display("FAIL j_pc got %h exp 20", PC); end
      INSTRUCTION = 32'h07FE_0000; ZERO = 1'b1;
      #1;
      checks++; if ({ALU_SELECT, NEG_SEL, WRITEENABLE} !== 5'b001_1_0) begin
         errors++; $display("FAIL beq_ctl got %b exp 00110", {ALU_SELECT, NEG_SEL, WRITEENABLE}); end
      step();
      checks++; if (PC !== 32'h1C) begin errors++; $display("FAIL beq_taken got %h exp 1c", PC); end
      INSTRUCTION = 32'h0103_0100;
      step();
      checks++; if (PC !== 32'h20) begin errors++; $display("FAIL mov_pc got %h exp 20", PC); end
      INSTRUCTION = 32'h07FE_0000; ZERO = 1'b0;
      step();
      checks++; if (PC !== 32'h24) begin errors++; $display("FAIL beq_not_taken got %h exp 24", PC); end
      INSTRUCTION = 32'h06FE_0000; ZERO = 1'b1;  // j back to 0x20
      step();
      checks++; if (PC !== 32'h20) begin errors++; $display("FAIL j_back got %h exp 20", PC); end
      INSTRUCTION = 32'h0802_0000; ZERO = 1'b0;
      step();
      checks++; if (PC !== 32'h2C) begin errors++; $display("FAIL bne_taken got %h exp 2c", PC); end
      checks++; if (RETIRED !== 16'd9) begin errors++; $display("FAIL br_retired got %0d exp 9", RETIRED); end
   endtask

   task automatic test_mem_stall();
      INSTRUCTION = 32'h0E04_0000; BUSYWAIT = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({MEM_READ, WRITEENABLE} !== 2'b10) begin
            errors++; $display("FAIL lwd_busy_ctl[%0d] got %b exp 10", i, {MEM_READ, WRITEENABLE}); end
         step();
         checks++; if (PC !== 32'h2C) begin errors++; $display("FAIL lwd_busy_pc[%0d] got %h exp 2c", i, PC); end
         checks++; if (RETIRED !== 16'd9) begin errors++; $display("FAIL lwd_busy_ret[%0d] got %0d exp 9", i, RETIRED); end
      end
      BUSYWAIT = 1'b0;
      #1;
      checks++; if ({MEM_READ, WRITEENABLE, WRITE_SRC} !== 3'b111) begin
         errors++; $display("FAIL lwd_done_ctl got %b exp 111", {MEM_READ, WRITEENABLE, WRITE_SRC}); end
      step();
      checks++; if (PC !== 32'h30) begin errors++; $display("FAIL lwd_done_pc got %h exp 30", PC); end
      checks++; if (RETIRED !== 16'd10) begin errors++; $display("FAIL lwd_done_ret got %0d exp 10", RETIRED); end
   endtask

   task automatic test_illegal();
      logic [31:0] prog    [5];
      logic [2:0]  exp_alu [5];
      logic        exp_mw  [5];
      prog    = '{32'h0101_0200, 32'h0401_0203, 32'h0501_0203, 32'h0A01_0003, 32'h1100_0110};
      exp_alu = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b000};
      exp_mw  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      INSTRUCTION = 32'h4200_0000;
      #1;
      checks++; if ({WRITEENABLE, MEM_READ, MEM_WRITE} !== 3'b000) begin
         errors++; $display("FAIL ill_strobes got %b exp 000", {WRITEENABLE, MEM_READ, MEM_WRITE}); end
      step();
      checks++; if (PC !== 32'h34) begin errors++; $display("FAIL ill_pc got %h exp 34", PC); end
      checks++; if (ILLEGAL !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", ILLEGAL); end
      checks++; if (RETIRED !== 16'd11) begin errors++; $display("FAIL ill_ret got %0d exp 11", RETIRED); end
      for (int i = 0; i < 5; i++) begin
         INSTRUCTION = prog[i];
         #1;
         checks++; if (ALU_SELECT !== exp_alu[i]) begin
            errors++; $display("FAIL ill_seq_alu[%0d] got %b exp %b", i, ALU_SELECT, exp_alu[i]); end
         checks++; if (MEM_WRITE !== exp_mw[i]) begin
            errors++; $display("FAIL ill_seq_mw[%0d] got %b exp %b", i, MEM_WRITE, exp_mw[i]); end
         step();
         checks++; if (ILLEGAL !== 1'b1) begin errors++; $display("FAIL ill_sticky[%0d] got %b exp 1", i, ILLEGAL); end
         checks++; if (PC !== 32'h34 + 32'(4 * (i + 1))) begin
            errors++; $display("FAIL ill_seq_pc[%0d] got %h exp %h", i, PC, 32'h34 + 32'(4 * (i + 1))); end
      end
      checks++; if (RETIRED !== 16'd16) begin errors++; $display("FAIL ill_seq_ret got %0d exp 16", RETIRED); end
   endtask

   task automatic test_halt();
      INSTRUCTION = 32'hFF00_0000;
      step();
      checks++; if (HALTED !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", HALTED); end
      checks++; if (PC !== 32'h48) begin errors++; $display("FAIL halt_pc got %h exp 48", PC); end
      checks++; if (RETIRED !== 16'd17) begin errors++; $display("FAIL halt_ret got %0d exp 17", RETIRED); end
      INSTRUCTION = 32'h0605_0000; ZERO = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if ({WRITEENABLE, MEM_READ, MEM_WRITE, ALU_SELECT} !== 6'b0) begin
            errors++; $display("FAIL halt_strobes[%0d] got %b exp 0", i, {WRITEENABLE, MEM_READ, MEM_WRITE, ALU_SELECT}); end
         step();
         checks++; if (PC !== 32'h48) begin errors++; $display("FAIL halt_frozen_pc[%0d] got %h exp 48", i, PC); end
         checks++; if (RETIRED !== 16'd17) begin errors++; $display("FAIL halt_frozen_ret[%0d] got %0d exp 17", i, RETIRED); end
      end
      ZERO = 1'b0;
   endtask

   task automatic test_wrap();
      RESET = 1'b0;
      step();
      RESET = 1'b1;
      checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL wrap_unhalt got %b exp 0", HALTED); end
      INSTRUCTION = 32'h06FE_0000;  // 0 + 4 - 8
      step();
      checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffc", PC); end
      INSTRUCTION = 32'h0600_0000;
      step();
      checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", PC); end
      checks++; if (RETIRED !== 16'd2) begin errors++; $display("FAIL wrap_ret got %0d exp 2", RETIRED); end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_branch();
      test_mem_stall();
      test_illegal();
      test_halt();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
